// File: rtl/apb_gpio_sequencer.sv
// apb_gpio_sequencer: APB master that replays a queued command stream
// (write OUT, write DIR, read IN, timed wait) against a GPIO slave.
// Each command becomes one zero-wait APB transfer or a cycle-count delay.
module apb_gpio_sequencer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [5:0]  OUT_OFFSET = 6'h18,
    parameter logic [5:0]  DIR_OFFSET = 6'h1C,
    parameter int          WAIT_W     = 16
) (
    input  logic        PCLK,
    input  logic        PRST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] OUT_ADDR = BASE_ADDR | {26'd0, OUT_OFFSET};
    localparam logic [31:0] DIR_ADDR = BASE_ADDR | {26'd0, DIR_OFFSET};

    typedef enum logic [1:0] {
        OP_WR_OUT = 2'b00,
        OP_WR_DIR = 2'b01,
        OP_RD_IN  = 2'b10,
        OP_WAIT   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] data;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t        fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    cmd_t        head;

    state_e      state;
    state_e      state_next;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    // No bypass: a pop in the same cycle does not reopen a full FIFO.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = (state != S_IDLE) || !empty;

    // Capture an accepted command into the slot under the write pointer.
    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{op: op_e'(cmd_op), data: cmd_data};
        end
    end

    // Advance the FIFO pointers on push and pop; they wrap naturally.
    // NOTE: clocked state uses non-blocking assignment so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              rd_active;
    logic              rd_active_d;
    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [31:0]       paddr_d;
    logic [31:0]       pwdata_d;
    logic              rsp_valid_d;
    logic [31:0]       rsp_data_d;

    // State register.
    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state selection: IDLE dispatches the FIFO head, transfers take
    // SETUP then ACCESS, a wait stays put until its counter reaches zero.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (pop) state_next = (head.op == OP_WAIT) ? S_WAIT : S_SETUP;
            end
            S_SETUP:  state_next = S_ACCESS;
            S_ACCESS: state_next = S_IDLE;
            S_WAIT: begin
                if (wait_cnt == '0) state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Next values for the registered APB, response and counter outputs.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        rd_active_d = rd_active;
        wait_cnt_d  = wait_cnt;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    if (head.op == OP_WAIT) begin
                        wait_cnt_d = head.data[WAIT_W-1:0];
                    end else begin
                        psel_d      = 1'b1;
                        pwrite_d    = (head.op != OP_RD_IN);
                        paddr_d     = (head.op == OP_WR_DIR) ? DIR_ADDR : OUT_ADDR;
                        pwdata_d    = (head.op == OP_RD_IN) ? 32'h0 : head.data;
                        rd_active_d = (head.op == OP_RD_IN);
                    end
                end
            end
            S_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                pwrite_d  = PWRITE;
            end
            S_ACCESS: begin
                if (rd_active) begin
                    rsp_data_d  = PRDATA;
                    rsp_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt != '0) wait_cnt_d = wait_cnt - WAIT_W'(1);
            end
            default: ;
        endcase
    end

    // Output registers; reset aborts any transfer or wait in flight.
    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= 32'h0;
            PWDATA    <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rd_active <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rd_active <= rd_active_d;
            wait_cnt  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_gpio_sequencer.sv
// tb_apb_gpio_sequencer: directed vector table, hand-written corner-case
// sequences and a randomized command stream, all compared every cycle
// against a schedule model derived from command push times.
module tb_apb_gpio_sequencer;

    localparam int DEPTH = 4;
    localparam int HIST  = 8192;

    logic        PCLK      = 1'b0;
    logic        PRST_N    = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op    = 2'b00;
    logic [31:0] cmd_data  = 32'h0;
    logic [31:0] PRDATA    = 32'h0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;

    apb_gpio_sequencer dut (
        .PCLK      (PCLK),
        .PRST_N    (PRST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Edge counter: cyc == k between rising edge k and rising edge k+1.
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s @cycle %0d: timed out", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: each command gets its pop and completion edges
    // at push time; per-cycle outputs follow from those edges.
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          push_e;
        int          pop_e;
        int          done_e;
    } mcmd_t;

    mcmd_t       mq [2048];
    int          n_cmd     = 0;
    int          base      = 0;
    int          prev_done = 0;
    logic [31:0] prd_hist [HIST];
    bit          chk_en    = 1'b0;
    bit          force_prd = 1'b0;
    logic [31:0] force_val = 32'h0;

    function automatic logic [31:0] addr_of(input logic [1:0] op);
        return (op == 2'b01) ? 32'h1C : 32'h18;
    endfunction

    function automatic int occupancy();
        int occ = 0;
        for (int i = base; i < n_cmd; i++) begin
            if (mq[i].push_e <= cyc) occ++;
            if (mq[i].pop_e <= cyc) occ--;
        end
        return occ;
    endfunction

    function automatic bit model_ready();
        return occupancy() < DEPTH;
    endfunction

    task automatic add_cmd(input logic [1:0] op, input logic [31:0] data);
        mcmd_t c;
        c.op     = op;
        c.data   = data;
        c.push_e = cyc + 1;
        c.pop_e  = (c.push_e > prev_done) ? c.push_e + 1 : prev_done + 1;
        c.done_e = (op == 2'b11) ? c.pop_e + int'(data[15:0]) + 1 : c.pop_e + 2;
        prev_done = c.done_e;
        mq[n_cmd] = c;
        n_cmd++;
    endtask

    // PRDATA changes every cycle; remember what the slave showed at each edge.
    always @(negedge PCLK) begin
        PRDATA = force_prd ? force_val : $urandom;
        prd_hist[(cyc + 1) % HIST] = PRDATA;
    end

    task automatic monitor();
        int          k;
        int          occ;
        bit          e_psel, e_pen, e_pw, e_rv, e_busy;
        logic [31:0] e_addr, e_wd, e_rd;
        k = cyc; occ = 0;
        e_psel = 0; e_pen = 0; e_pw = 0; e_rv = 0; e_busy = 0;
        e_addr = 32'h0; e_wd = 32'h0; e_rd = 32'h0;
        for (int i = base; i < n_cmd; i++) begin
            if (mq[i].push_e <= k) begin
                occ++;
                if (mq[i].pop_e <= k) occ--;
                if (k < mq[i].done_e) e_busy = 1;
                if (mq[i].op != 2'b11 && mq[i].pop_e <= k) begin
                    e_addr = addr_of(mq[i].op);
                    e_wd   = (mq[i].op == 2'b10) ? 32'h0 : mq[i].data;
                    if (k <= mq[i].pop_e + 1) begin
                        e_psel = 1;
                        e_pen  = (k == mq[i].pop_e + 1);
                        e_pw   = (mq[i].op != 2'b10);
                    end
                end
                if (mq[i].op == 2'b10 && mq[i].done_e <= k) begin
                    e_rd = prd_hist[mq[i].done_e % HIST];
                    if (mq[i].done_e == k) e_rv = 1;
                end
            end
        end
        check("m_cmd_ready", cmd_ready, occ < DEPTH);
        check("m_busy",      busy,      e_busy);
        check("m_psel",      PSEL,      e_psel);
        check("m_penable",   PENABLE,   e_pen);
        check("m_pwrite",    PWRITE,    e_pw);
        check("m_paddr",     PADDR,     e_addr);
        check("m_pwdata",    PWDATA,    e_wd);
        check("m_rsp_valid", rsp_valid, e_rv);
        check("m_rsp_data",  rsp_data,  e_rd);
    endtask

    always @(negedge PCLK) if (chk_en) monitor();

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered and left at a falling edge)
    // ------------------------------------------------------------------
    task automatic push(input logic [1:0] op, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int t = 0; t < 100; t++) begin
            if (model_ready()) begin
                add_cmd(op, data);
                @(negedge PCLK);
                return;
            end
            @(negedge PCLK);
        end
        timeout_fail("push");
    endtask

    task automatic idle_in();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            if (!busy) return;
            @(negedge PCLK);
        end
        timeout_fail("wait_idle");
    endtask

    task automatic wait_psel(output bit found);
        found = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (PSEL) begin
                found = 1'b1;
                return;
            end
            @(negedge PCLK);
        end
        timeout_fail("wait_psel");
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] prdata;
        logic [31:0] exp_addr;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic        exp_rv;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit found;
        int t0;

        vecs[0] = '{2'b01, 32'hFFFF_0000, 32'h0,         32'h1C, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0};
        vecs[1] = '{2'b00, 32'hA5A5_A5A5, 32'h0,         32'h18, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'h1234_5678, 32'h18, 1'b0, 32'h0,         1'b1, 32'h1234_5678};
        vecs[3] = '{2'b00, 32'h0000_0000, 32'h0,         32'h18, 1'b1, 32'h0,         1'b0, 32'h0};
        vecs[4] = '{2'b01, 32'h0000_FFFF, 32'h0,         32'h1C, 1'b1, 32'h0000_FFFF, 1'b0, 32'h0};
        vecs[5] = '{2'b10, 32'h5555_0000, 32'hDEAD_BEEF, 32'h18, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};

        // Reset values.
        repeat (2) @(negedge PCLK);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy",      busy,      0);
        check("rst_psel",      PSEL,      0);
        check("rst_penable",   PENABLE,   0);
        check("rst_paddr",     PADDR,     0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data",  rsp_data,  0);
        #2;
        PRST_N    = 1'b1;
        prev_done = cyc;
        chk_en    = 1'b1;
        @(negedge PCLK);

        // Vector table: one command each, full APB handshake checked.
        for (int v = 0; v < 6; v++) begin
            force_prd = 1'b1;
            force_val = vecs[v].prdata;
            push(vecs[v].op, vecs[v].data);
            idle_in();
            wait_psel(found);
            if (found) begin
                check("vec_setup_addr",    PADDR,   vecs[v].exp_addr);
                check("vec_setup_write",   PWRITE,  vecs[v].exp_write);
                check("vec_setup_wdata",   PWDATA,  vecs[v].exp_wdata);
                check("vec_setup_penable", PENABLE, 0);
                @(negedge PCLK);
                check("vec_access_psel",    PSEL,    1);
                check("vec_access_penable", PENABLE, 1);
                @(negedge PCLK);
                check("vec_end_psel",      PSEL,      0);
                check("vec_end_rsp_valid", rsp_valid, vecs[v].exp_rv);
                if (vecs[v].exp_rv) check("vec_end_rsp_data", rsp_data, vecs[v].exp_rsp);
            end
            wait_idle();
        end
        force_prd = 1'b0;

        // Idle afterwards: busy low and last read data held.
        repeat (3) @(negedge PCLK);
        check("hold_busy",     busy,     0);
        check("hold_rsp_data", rsp_data, 32'hDEAD_BEEF);

        // FIFO fill behind a long wait, then the fifth accept after a pop.
        t0 = cyc + 1;
        push(2'b11, 32'd10);
        push(2'b00, 32'h0000_0011);
        push(2'b01, 32'h0000_0022);
        push(2'b10, 32'h0000_0033);
        push(2'b00, 32'h0000_0044);
        check("full_ready_low", cmd_ready, 0);
        push(2'b01, 32'h0000_0055);
        check("fifth_accept_edge", cyc - t0, 14);
        idle_in();
        wait_idle();

        // WAIT 3 then a write: four cycles in WAIT, one in IDLE, then SETUP.
        t0 = cyc + 1;
        push(2'b11, 32'h0000_0003);
        push(2'b00, 32'h0000_0001);
        idle_in();
        wait_psel(found);
        if (found) check("wait3_setup_edge", cyc - t0, 6);
        wait_idle();

        // WAIT 0 (upper data bits ignored): a single cycle in WAIT.
        t0 = cyc + 1;
        push(2'b11, 32'hABCD_0000);
        push(2'b00, 32'h0000_0002);
        idle_in();
        wait_psel(found);
        if (found) check("wait0_setup_edge", cyc - t0, 3);
        wait_idle();

        // Reset during ACCESS with two commands still queued.
        push(2'b00, 32'h1111_1111);
        push(2'b01, 32'h2222_2222);
        push(2'b10, 32'h3333_3333);
        idle_in();
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (PENABLE) found = 1'b1;
            else         @(negedge PCLK);
        end
        if (!found) timeout_fail("wait_access");
        #2;
        PRST_N = 1'b0;
        chk_en = 1'b0;
        #1;
        check("arst_psel",      PSEL,      0);
        check("arst_penable",   PENABLE,   0);
        check("arst_busy",      busy,      0);
        check("arst_cmd_ready", cmd_ready, 1);
        base = n_cmd;
        repeat (3) @(negedge PCLK);
        #2;
        PRST_N    = 1'b1;
        prev_done = cyc;
        chk_en    = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge PCLK);
            check("post_rst_psel", PSEL, 0);
            check("post_rst_busy", busy, 0);
        end

        // Randomized command stream with random gaps.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  op;
            logic [31:0] data;
            int          gap;
            op   = 2'($urandom_range(0, 3));
            data = (op == 2'b11) ? {16'($urandom), 16'($urandom_range(0, 5))} : $urandom;
            push(op, data);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                idle_in();
                repeat (gap) @(negedge PCLK);
            end
        end
        idle_in();
        wait_idle();
        repeat (4) @(negedge PCLK);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
